// File: rtl/ledcube_pkg.sv
// ledcube_pkg: shared FSM states and sizing/address helpers for the LED cube layer scanner.
package ledcube_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BLANK,
        S_RD,
        S_PRESENT,
        S_WAIT,
        S_SHOW
    } state_t;

    // Counter width that stays at least one bit even for a count of one.
    function automatic int wclog2(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

    // Buffer is the most significant field and channel the least, so a layer is one contiguous run.
    function automatic int pack_addr(input int bsel, lyr, bidx, cidx, nl, nb, nc);
        return ((bsel * nl + lyr) * nb + bidx) * nc + cidx;
    endfunction

endpackage

// File: rtl/ledcube_dwell_timer.sv
// ledcube_dwell_timer: loadable down-counter; expire is high in the last cycle of a loaded interval.
module ledcube_dwell_timer #(
    parameter int W = 13
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expire
);

    logic [W-1:0] cnt;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) cnt <= '0;
        else if (load) cnt <= value;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    end

    assign expire = cnt == W'(1);

endmodule

// File: rtl/ledcube_layer_scanner.sv
// ledcube_layer_scanner: double-buffered LED cube refresh engine; streams each layer to the
// I2C channels, then lights it between blanking gaps, swapping buffers only at frame boundaries.
module ledcube_layer_scanner
    import ledcube_pkg::*;
#(
    parameter int NUM_LAYERS   = 8,
    parameter int NUM_CHANNELS = 4,
    parameter int BYTES_PER_CH = 16,
    parameter int DATA_W       = 8,
    parameter int BLANK_CYCLES = 64,
    parameter int SHOW_CYCLES  = 4096,
    localparam int ADDR_W = 1 + $clog2(NUM_LAYERS * NUM_CHANNELS * BYTES_PER_CH)
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic                           enable,
    input  logic                           swap_req,
    output logic                           swap_ack,
    output logic                           display_buf,
    output logic [ADDR_W-1:0]              mem_rd_addr,
    input  logic [DATA_W-1:0]              mem_rd_data,
    output logic [NUM_CHANNELS-1:0]        ch_valid,
    output logic [NUM_CHANNELS*DATA_W-1:0] ch_data,
    output logic [NUM_CHANNELS-1:0]        ch_last,
    input  logic [NUM_CHANNELS-1:0]        ch_ready,
    input  logic [NUM_CHANNELS-1:0]        ch_done,
    output logic [NUM_LAYERS-1:0]          layer_active,
    output logic                           frame_start
);

    localparam int LW = wclog2(NUM_LAYERS);
    localparam int BW = wclog2(BYTES_PER_CH);
    localparam int CW = wclog2(NUM_CHANNELS);
    localparam int TW = wclog2((BLANK_CYCLES > SHOW_CYCLES ? BLANK_CYCLES : SHOW_CYCLES) + 1);

    state_t                  state, nxt;
    logic [LW-1:0]           layer;
    logic [BW-1:0]           bidx;
    logic [CW-1:0]           cidx;
    logic [NUM_CHANNELS-1:0] done_flags;
    logic [TW-1:0]           load_val;
    logic                    loaded, pending, expire, load, xfer, last_c, last_byte, boundary, do_swap;

    ledcube_dwell_timer #(.W(TW)) u_timer (
        .clock (clock),
        .resetn(resetn),
        .load  (load),
        .value (load_val),
        .expire(expire)
    );

    always_comb begin
        last_c    = cidx == CW'(NUM_CHANNELS - 1);
        last_byte = last_c && bidx == BW'(BYTES_PER_CH - 1);
        xfer      = state == S_PRESENT && loaded && ch_ready[cidx];
        boundary  = state == S_SHOW && expire && layer == LW'(NUM_LAYERS - 1);
        do_swap   = boundary && (pending || swap_req);
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:    nxt = enable ? S_BLANK : S_IDLE;
            S_BLANK:   nxt = expire ? S_RD : S_BLANK;
            S_RD:      nxt = S_PRESENT;
            S_PRESENT: nxt = xfer ? (last_byte ? S_WAIT : S_RD) : S_PRESENT;
            S_WAIT:    nxt = &done_flags ? S_SHOW : S_WAIT;
            S_SHOW:    nxt = expire ? (enable ? S_BLANK : S_IDLE) : S_SHOW;
            default:   nxt = S_IDLE;
        endcase
    end

    assign load     = nxt != state && (nxt == S_BLANK || nxt == S_SHOW);
    assign load_val = TW'(nxt == S_SHOW ? SHOW_CYCLES : BLANK_CYCLES);

    always_comb begin
        layer_active = state == S_SHOW ? NUM_LAYERS'(1) << layer : '0;
        ch_valid     = state == S_PRESENT && loaded ? NUM_CHANNELS'(1) << cidx : '0;
        ch_last      = bidx == BW'(BYTES_PER_CH - 1) ? ch_valid : '0;
        mem_rd_addr  = state == S_RD ? ADDR_W'(pack_addr(int'(display_buf), int'(layer), int'(bidx),
                                                         int'(cidx), NUM_LAYERS, BYTES_PER_CH,
                                                         NUM_CHANNELS)) : '0;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            layer       <= '0;
            bidx        <= '0;
            cidx        <= '0;
            loaded      <= 1'b0;
            pending     <= 1'b0;
            display_buf <= 1'b0;
            swap_ack    <= 1'b0;
            frame_start <= 1'b0;
            done_flags  <= '0;
            ch_data     <= '0;
        end else begin
            state       <= nxt;
            swap_ack    <= do_swap;
            display_buf <= display_buf ^ do_swap;
            pending     <= boundary ? 1'b0 : pending | swap_req;
            frame_start <= nxt == S_BLANK && state != S_BLANK && (state == S_IDLE || boundary);
            done_flags  <= load && nxt == S_BLANK ? '0 : done_flags | ch_done;
            // First PRESENT cycle captures the BRAM word; valid is offered from the next cycle on.
            loaded      <= state == S_PRESENT && !xfer;
            if (state == S_PRESENT && !loaded) ch_data[cidx*DATA_W +: DATA_W] <= mem_rd_data;
            if (state == S_SHOW && expire) layer <= enable ? layer + 1'b1 : '0;
            if (xfer) begin
                cidx <= last_c ? '0 : cidx + 1'b1;
                if (last_c) bidx <= bidx == BW'(BYTES_PER_CH - 1) ? '0 : bidx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ledcube_layer_scanner.sv
// tb_ledcube_layer_scanner: random frame contents checked against a transfer-level model of
// layer order, byte order, buffer swaps, blanking/show timing, stalls, enable and reset.
module tb_ledcube_layer_scanner;

    localparam int NL = 8, NC = 4, NB = 16, DW = 8, BLANK = 64, SHOW = 300;
    localparam int LAYER_BYTES = NC * NB;
    localparam int BUF_BYTES = NL * LAYER_BYTES;
    localparam int LIMIT = 20000;

    logic clock = 0, resetn = 0, enable = 0, swap_req = 0;
    logic swap_ack, display_buf, frame_start;
    logic [9:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic [NC-1:0] ch_valid, ch_last;
    logic [NC-1:0] ch_ready = '1, ch_done = '0;
    logic [NC*DW-1:0] ch_data;
    logic [NL-1:0] layer_active;

    int checks = 0, errors = 0, cyc = 0;
    int exp_buf, exp_layer, k, lit_len, blank_start, acks;
    bit pend, idle, seen_valid, en_prev, sreq_prev;
    logic [NC-1:0] prev_stall;
    logic [NC*DW-1:0] prev_data;
    int done_cnt[NC];
    logic [DW-1:0] mem [2*BUF_BYTES];

    ledcube_layer_scanner #(
        .NUM_LAYERS(NL), .NUM_CHANNELS(NC), .BYTES_PER_CH(NB), .DATA_W(DW),
        .BLANK_CYCLES(BLANK), .SHOW_CYCLES(SHOW)
    ) dut (
        .clock(clock), .resetn(resetn), .enable(enable), .swap_req(swap_req),
        .swap_ack(swap_ack), .display_buf(display_buf), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data), .ch_valid(ch_valid), .ch_data(ch_data), .ch_last(ch_last),
        .ch_ready(ch_ready), .ch_done(ch_done), .layer_active(layer_active),
        .frame_start(frame_start)
    );

    always #5 clock = ~clock;

    always @(posedge clock) mem_rd_data <= mem[mem_rd_addr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic model_reset();
        exp_buf = 0; exp_layer = 0; k = 0; lit_len = 0; blank_start = 0; acks = 0;
        pend = 0; idle = 1; seen_valid = 0; en_prev = 0; sreq_prev = 0;
        prev_stall = '0; prev_data = '0; ch_done = '0;
        foreach (done_cnt[i]) done_cnt[i] = 0;
    endtask

    // Observe the current cycle against the model, then advance one clock.
    task automatic tick();
        bit ack_exp, fs_exp;
        int ch, addr;
        ack_exp = 0;
        fs_exp = 0;
        if (!idle && lit_len != 0 && layer_active == '0) begin
            chk("show_len", lit_len, SHOW);
            lit_len = 0;
            if (exp_layer == NL - 1) begin
                ack_exp = pend | sreq_prev;
                exp_buf ^= int'(ack_exp);
                pend = 0;
            end else pend |= sreq_prev;
            k = 0;
            seen_valid = 0;
            blank_start = cyc;
            if (en_prev) begin
                exp_layer = (exp_layer + 1) % NL;
                fs_exp = exp_layer == 0;
            end else begin
                idle = 1;
                exp_layer = 0;
            end
        end else begin
            pend |= sreq_prev;
            if (idle && en_prev) begin
                idle = 0; fs_exp = 1; blank_start = cyc; k = 0; seen_valid = 0;
            end
        end
        if (swap_ack) acks++;
        chk("swap_ack", swap_ack, ack_exp);
        chk("frame_start", frame_start, fs_exp);
        chk("display_buf", display_buf, exp_buf);
        if (idle) chk("idle_dark", {ch_valid, layer_active}, 0);
        if (layer_active != '0) begin
            if (lit_len == 0) chk("bytes_before_lit", k, LAYER_BYTES);
            chk("lit_onehot", layer_active, 1 << exp_layer);
            lit_len++;
        end
        for (int c = 0; c < NC; c++) if (prev_stall[c]) begin
            chk("hold_valid", ch_valid[c], 1);
            chk("hold_data", ch_data[c*DW +: DW], prev_data[c*DW +: DW]);
        end
        if (ch_valid != '0) begin
            chk("valid_onehot", $onehot(ch_valid), 1);
            chk("dark_streaming", layer_active, 0);
            if (!seen_valid) begin
                chk("blank_to_first_byte", cyc - blank_start, BLANK + 2);
                seen_valid = 1;
            end
            if ((ch_valid & ch_ready) != '0) begin
                ch = k % NC;
                addr = exp_buf * BUF_BYTES + exp_layer * LAYER_BYTES + k;
                chk("xfer_chan", ch_valid, 1 << ch);
                chk("xfer_data", ch_data[ch*DW +: DW], mem[addr % (2*BUF_BYTES)]);
                chk("xfer_last", ch_last, k / NC == NB - 1 ? ch_valid : 0);
                if (k / NC == NB - 1) done_cnt[ch] = 5;
                k++;
            end
        end
        prev_stall = ch_valid & ~ch_ready;
        prev_data = ch_data;
        en_prev = enable;
        sreq_prev = swap_req;
        @(posedge clock);
        #1;
        cyc++;
        for (int c = 0; c < NC; c++) begin
            ch_done[c] = 1'b0;
            if (done_cnt[c] != 0) begin
                done_cnt[c]--;
                ch_done[c] = done_cnt[c] == 0;
            end
        end
    endtask

    initial begin
        int n;
        foreach (mem[i]) mem[i] = DW'($urandom);
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("reset_outputs", {swap_ack, display_buf, mem_rd_addr, ch_valid, ch_last, ch_data,
                              layer_active, frame_start}, 0);
        resetn = 1;
        repeat (5) tick();
        enable = 1;

        n = 0; while (!(exp_layer == 3 && k == 10) && n < LIMIT) begin tick(); n++; end
        chk("reach_swap_point", n < LIMIT, 1);
        swap_req = 1; tick(); swap_req = 0;
        repeat (10) tick();
        swap_req = 1; tick(); swap_req = 0;
        n = 0; while (exp_buf != 1 && n < LIMIT) begin tick(); n++; end
        chk("reach_frame_end", n < LIMIT, 1);
        chk("single_ack", acks, 1);
        chk("buf_after_swap", display_buf, 1);

        n = 0; while (!(exp_layer == 2 && k == 20) && n < LIMIT) begin tick(); n++; end
        chk("reach_stall_point", n < LIMIT, 1);
        ch_ready = 4'b1011;
        repeat (100) tick();
        chk("stall_blocks_ch2", k, 22);
        ch_ready = '1;

        n = 0; while (!(exp_layer == 3 && layer_active != '0) && n < LIMIT) begin tick(); n++; end
        chk("reach_layer3_show", n < LIMIT, 1);
        enable = 0;
        n = 0; while (!idle && n < LIMIT) begin tick(); n++; end
        chk("reach_idle", n < LIMIT, 1);
        repeat (50) tick();
        chk("idle_dark_after_disable", layer_active, 0);
        enable = 1;
        n = 0; while (!(!idle && k == 30 && ch_valid != '0) && n < LIMIT) begin tick(); n++; end
        chk("reach_reset_point", n < LIMIT, 1);

        resetn = 0;
        enable = 0;
        #2;
        chk("async_reset_outputs", {swap_ack, display_buf, mem_rd_addr, ch_valid, ch_last, ch_data,
                                    layer_active, frame_start}, 0);
        model_reset();
        repeat (3) tick();
        resetn = 1;
        repeat (20) tick();
        chk("buf_after_reset", display_buf, 0);
        enable = 1;
        n = 0; while (exp_layer != 1 && n < LIMIT) begin tick(); n++; end
        chk("restart_layer0", n < LIMIT, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
